// File: rtl/vector_ram_pkg.sv
// Shared types and helpers for the vector ping-pong RAM cfg loader.
package vector_ram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH,
        DONE
    } loader_state_t;

    function automatic int unsigned beats(input int unsigned length,
                                          input int unsigned parallelism);
        return length / parallelism;
    endfunction

endpackage

// File: rtl/vector_req_reg.sv
// One-entry valid/ready register; accepts a new entry in the same cycle the old one drains.
module vector_req_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        in_ready_o = !valid_q || out_ready_i;
        valid_d    = valid_q;
        data_d     = data_q;
        if (in_valid_i && in_ready_o) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/vector_ping_pong_cfg_loader.sv
// Streams PARALLELISM-wide beats into one bank of the ping-pong RAM through its cfg port,
// holding cfg_en/ping for the whole load so the compute side keeps the other bank.
module vector_ping_pong_cfg_loader
    import vector_ram_pkg::*;
#(
    parameter int unsigned  LENGTH      = 32,
    parameter int unsigned  DATA_WIDTH  = 32,
    parameter int unsigned  PARALLELISM = 4,
    localparam int unsigned ADDR_WIDTH  = $clog2(LENGTH),
    localparam int unsigned BEATS       = beats(LENGTH, PARALLELISM)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              bank_sel,
    input  logic [PARALLELISM*DATA_WIDTH-1:0] s_data,
    input  logic                              s_valid,
    input  logic                              s_last,
    output logic                              s_ready,
    output logic                              cfg_en,
    output logic                              ping,
    output logic                              cfg_valid,
    output logic                              cfg_write,
    output logic                              cfg_rready,
    output logic [PARALLELISM*ADDR_WIDTH-1:0] cfg_addr,
    output logic [PARALLELISM*DATA_WIDTH-1:0] cfg_wdata,
    input  logic                              cfg_ready,
    output logic                              busy,
    output logic                              done,
    output logic                              err_len
);

    localparam int unsigned CNT_WIDTH = $clog2(BEATS) + 1;
    localparam int unsigned AW_ALL    = PARALLELISM * ADDR_WIDTH;
    localparam int unsigned DW_ALL    = PARALLELISM * DATA_WIDTH;

    if (LENGTH % PARALLELISM != 0) begin : g_bad_length
        $fatal(1, "LENGTH must be a multiple of PARALLELISM");
    end

    loader_state_t        state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ping_q, ping_d;
    logic                 err_q, err_d;

    logic              req_ready;
    logic              beat_acc;
    logic              last_beat;
    logic [AW_ALL-1:0] beat_addr;
    logic [AW_ALL+DW_ALL-1:0] req_out;

    // Lane i of beat k targets element k*PARALLELISM+i; cnt never exceeds BEATS-1 here.
    always_comb begin
        beat_addr = '0;
        for (int i = 0; i < PARALLELISM; i++) begin
            beat_addr[i*ADDR_WIDTH +: ADDR_WIDTH] =
                ADDR_WIDTH'(32'(cnt_q) * PARALLELISM + 32'(i));
        end
    end

    assign s_ready   = (state_q == LOAD) && req_ready;
    assign beat_acc  = s_valid && s_ready;
    assign last_beat = (cnt_q == CNT_WIDTH'(BEATS - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ping_d  = ping_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    ping_d  = bank_sel;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (beat_acc) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (last_beat || s_last) begin
                        state_d = FLUSH;
                        // Early s_last, or a full vector without s_last on its final beat.
                        if (last_beat != s_last) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            FLUSH: begin
                if (!cfg_valid || cfg_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ping_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ping_q  <= ping_d;
            err_q   <= err_d;
        end
    end

    vector_req_reg #(
        .WIDTH (AW_ALL + DW_ALL)
    ) u_req_reg (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (beat_acc),
        .in_ready_o  (req_ready),
        .in_data_i   ({beat_addr, s_data}),
        .out_valid_o (cfg_valid),
        .out_ready_i (cfg_ready),
        .out_data_o  (req_out)
    );

    assign cfg_addr   = req_out[AW_ALL+DW_ALL-1:DW_ALL];
    assign cfg_wdata  = req_out[DW_ALL-1:0];
    assign cfg_write  = cfg_valid;
    assign cfg_rready = 1'b0;
    assign cfg_en     = (state_q == LOAD) || (state_q == FLUSH);
    assign ping       = ping_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign err_len    = err_q;

endmodule
